// File: rtl/bus_wait_slave_if.sv
// Request/response bundle between a bus master and bus_wait_slave.
// Strobes and ready are active low.
interface bus_wait_slave_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [31:0] s_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (
    output cs_, as_, rw, s_addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, s_addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/bus_wait_slave.sv
// Wait-state bus slave: seven R/W registers plus a transaction counter,
// answering each request with a single registered ready pulse.
module bus_wait_slave #(
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  bus_wait_slave_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q;
  logic [31:0] regs_q [0:6];

  logic        accept;
  logic [2:0]  sel_idx;
  logic        sel_rw;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{bus.s_addr[31:5], bus.s_addr[1:0]};

  assign bus.rd_data = rdata_q;
  assign bus.rdy_    = rdy_q;

  always_comb begin
    accept  = (state_q == S_IDLE) && !bus.cs_ && !bus.as_;
    sel_idx = accept ? bus.s_addr[4:2] : idx_q;
    sel_rw  = accept ? bus.rw : rw_q;
    rd_mux  = (sel_idx == 3'd7) ? cnt_q : regs_q[sel_idx];

    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d   = bus.s_addr[4:2];
          rw_d    = bus.rw;
          wdata_d = bus.wr_data;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WLOAD;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_ACK;
        else wcnt_d = wcnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered on entry to ACK so they hold for that cycle
    rdy_d   = (state_d != S_ACK);
    rdata_d = (state_d == S_ACK && sel_rw) ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdy_q   <= 1'b1;
      rdata_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 7; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      if (state_q == S_ACK) begin
        cnt_q <= cnt_q + 32'd1;
        if (!rw_q && idx_q != 3'd7) regs_q[idx_q] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_wait_slave.sv
// Scoreboard bench for bus_wait_slave: one instance with two wait states
// and one with none, sharing clock and reset.
module tb_bus_wait_slave;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses [0:1];

  exp_t q [$];
  exp_t q0 [$];

  logic [31:0] mem [0:1][0:7];
  logic [31:0] cnt [0:1];

  bus_wait_slave_if bi ();
  bus_wait_slave_if bi0 ();

  bus_wait_slave #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bi)
  );

  bus_wait_slave #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bi0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bi.rdy_ === 1'b0) begin
      exp_t e;
      pulses[0]++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rdy_w2: unexpected pulse cyc=%0d data=%h", cyc, bi.rd_data);
      end else begin
        e = q.pop_front();
        if (bi.rd_data !== e.data || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL ack_w2: got data=%h cyc=%0d, want data=%h cyc=%0d",
                   bi.rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bi0.rdy_ === 1'b0) begin
      exp_t e;
      pulses[1]++;
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rdy_w0: unexpected pulse cyc=%0d data=%h", cyc, bi0.rd_data);
      end else begin
        e = q0.pop_front();
        if (bi0.rd_data !== e.data || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL ack_w0: got data=%h cyc=%0d, want data=%h cyc=%0d",
                   bi0.rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic idle_bus();
    bi.cs_ = 1'b1;  bi.as_ = 1'b1;  bi.rw = 1'b1;
    bi.s_addr = '0; bi.wr_data = '0;
    bi0.cs_ = 1'b1; bi0.as_ = 1'b1; bi0.rw = 1'b1;
    bi0.s_addr = '0; bi0.wr_data = '0;
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      cnt[s] = '0;
      for (int i = 0; i < 8; i++) mem[s][i] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_model();
  endtask

  // s = 0 targets the two-wait instance, s = 1 the zero-wait one
  task automatic issue(input bit s, input bit rw, input logic [31:0] addr,
                       input logic [31:0] wd, output int c);
    logic [31:0] e;
    logic [2:0]  ix;
    int          w;
    ix = addr[4:2];
    e  = rw ? ((ix == 3'd7) ? cnt[s] : mem[s][ix]) : 32'd0;
    if (!rw && ix != 3'd7) mem[s][ix] = wd;
    cnt[s] = cnt[s] + 32'd1;
    @(negedge clk);
    if (s) begin
      bi0.cs_ = 1'b0; bi0.as_ = 1'b0; bi0.rw = rw;
      bi0.s_addr = addr; bi0.wr_data = wd;
    end else begin
      bi.cs_ = 1'b0; bi.as_ = 1'b0; bi.rw = rw;
      bi.s_addr = addr; bi.wr_data = wd;
    end
    @(posedge clk);
    #1;
    c = cyc;
    idle_bus();
    w = s ? 0 : 2;
    if (s) q0.push_back('{e, c + w});
    else q.push_back('{e, c + w});
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0 && q0.size() == 0) break;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (q.size() != 0 || q0.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending w2=%0d w0=%0d, want 0 0", q.size(), q0.size());
      q.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic xfer(input bit s, input bit rw, input logic [31:0] addr,
                      input logic [31:0] wd);
    int c;
    issue(s, rw, addr, wd, c);
    wait_drain(20);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bi.rdy_ !== 1'b1 || bi.rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_w2: rdy_=%b rd_data=%h, want 1 0", bi.rdy_, bi.rd_data);
    end
    n_checks++;
    if (bi0.rdy_ !== 1'b1 || bi0.rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_w0: rdy_=%b rd_data=%h, want 1 0", bi0.rdy_, bi0.rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    for (int i = 0; i < 8; i++) xfer(1'b0, 1'b1, 32'(i * 4), '0);
  endtask

  task automatic test_write_read();
    xfer(1'b0, 1'b0, 32'h14, 32'hDEADBEEF);
    xfer(1'b0, 1'b1, 32'h14, '0);
    xfer(1'b0, 1'b1, 32'h34, '0);
    xfer(1'b0, 1'b0, 32'hFFFF_FFE0, 32'h0BAD_F00D);
    xfer(1'b0, 1'b1, 32'h0000_0000, '0);
  endtask

  task automatic test_ignored();
    int p0, c;
    p0 = pulses[0];
    @(negedge clk);
    bi.cs_ = 1'b1; bi.as_ = 1'b0; bi.rw = 1'b0;
    bi.s_addr = 32'h8; bi.wr_data = 32'h1;
    @(negedge clk);
    idle_bus();
    repeat (6) @(negedge clk);
    n_checks++;
    if (pulses[0] !== p0) begin
      n_fail++;
      $display("FAIL cs_high: pulses=%0d, want %0d", pulses[0] - p0, 0);
    end
    p0 = pulses[0];
    issue(1'b0, 1'b1, 32'h14, '0, c);
    @(negedge clk);
    bi.cs_ = 1'b0; bi.as_ = 1'b0; bi.rw = 1'b0;
    bi.s_addr = 32'h14; bi.wr_data = 32'h5555_5555;
    @(negedge clk);
    idle_bus();
    wait_drain(20);
    repeat (4) @(negedge clk);
    n_checks++;
    if (pulses[0] - p0 !== 1) begin
      n_fail++;
      $display("FAIL wait_strobe: pulses=%0d, want %0d", pulses[0] - p0, 1);
    end
    xfer(1'b0, 1'b1, 32'h14, '0);
  endtask

  task automatic test_cnt();
    do_reset(2);
    for (int i = 0; i < 3; i++) xfer(1'b0, 1'b0, 32'h8, 32'(i));
    xfer(1'b0, 1'b1, 32'h1C, '0);
    xfer(1'b0, 1'b0, 32'h1C, 32'h12345678);
    xfer(1'b0, 1'b1, 32'h1C, '0);
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset(1);
    p0 = pulses[0];
    @(negedge clk);
    bi.cs_ = 1'b0; bi.as_ = 1'b0; bi.rw = 1'b0;
    bi.s_addr = 32'h4; bi.wr_data = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    idle_bus();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    repeat (6) @(negedge clk);
    n_checks++;
    if (pulses[0] !== p0) begin
      n_fail++;
      $display("FAIL abort: pulses=%0d, want %0d", pulses[0] - p0, 0);
    end
    xfer(1'b0, 1'b1, 32'h1C, '0);
    xfer(1'b0, 1'b1, 32'h4, '0);
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    xfer(1'b1, 1'b0, 32'h0, 32'h1111_1111);
    xfer(1'b1, 1'b0, 32'h4, 32'h2222_2222);
    issue(1'b1, 1'b1, 32'h0, '0, c1);
    @(negedge clk);
    issue(1'b1, 1'b1, 32'h4, '0, c2);
    wait_drain(20);
    n_checks++;
    if (c2 - c1 !== 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, want %0d", c2 - c1, 2);
    end
    xfer(1'b1, 1'b1, 32'h1C, '0);
  endtask

  initial begin
    pulses[0] = 0;
    pulses[1] = 0;
    idle_bus();
    reset_model();
    test_reset();
    test_write_read();
    test_ignored();
    test_cnt();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_wait_slave.md
# bus_wait_slave

Generic memory-mapped bus slave that answers requests routed to it by the bus address decoder's active-low chip select. It latches a request, inserts a fixed number of wait states, then completes the transfer with a one-cycle active-low ready pulse. It holds seven read/write 32-bit registers and one read-only transaction counter. It serves as the reference responder for bus bring-up and as the template for peripheral slaves.

## Interface
- WAIT_CYCLES, 2, wait states between request accept and ready pulse; legal range 0..15
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- cs_  in  1  chip select from the address decoder, active low
- as_  in  1  address strobe, active low; one-cycle request pulse
- rw  in  1  1 = read, 0 = write
- s_addr  in  32  byte address; only bits [4:2] (the register index) are used
- wr_data  in  32  write data; sampled together with the request
- rd_data  out  32  read data; valid only while rdy_ = 0, otherwise 0
- rdy_  out  1  ready / transfer-complete pulse, active low

## Operation
- Register map (index = s_addr[4:2]):
  - Index 0..6: general R/W registers.
  - Index 7: CNT, read-only count of completed transactions. Writes to CNT are discarded but still counted.
- FSM states:
  - IDLE: a request is accepted when cs_ = 0 and as_ = 0 on the same edge. The FSM latches index, rw and wr_data. It goes to WAIT if WAIT_CYCLES > 0, otherwise to ACK.
  - WAIT: a 4-bit down-counter is loaded with WAIT_CYCLES-1 on accept and decrements each cycle. The FSM goes to ACK when the counter reaches 0.
  - ACK: rdy_ = 0 for exactly one cycle, then the FSM returns to IDLE.
    - Read: rd_data = the selected register (CNT value before this transaction's increment).
    - Write: rd_data = 0, and the register is updated at the end of the ACK cycle.
    - CNT increments at the end of the ACK cycle. It wraps from 0xFFFFFFFF to 0x00000000.
- Strobes (as_ low) during WAIT or ACK are ignored. No queueing, no error response; the master must not issue a request until it has seen rdy_.
- as_ low with cs_ high: ignored (request addressed to another slave).
- s_addr bits other than [4:2] are don't-care, so the register map aliases every 32 bytes.
- reset = 1 at any edge:
  - state = IDLE, rdy_ = 1, rd_data = 0, all registers and CNT = 0.
  - An in-flight transaction is aborted: no write, no count, no ready pulse.
  - The request sampling logic is held inactive on that edge.

## Timing
- Request sampled at edge T; rdy_ is low during cycle T+1+WAIT_CYCLES.
  - WAIT_CYCLES = 0: rdy_ low in cycle T+1.
  - WAIT_CYCLES = 2: rdy_ low in cycle T+3.
- rdy_ and rd_data are registered outputs with no combinational path from inputs.
- Back-to-back transfers: the earliest next accept is the edge ending the cycle after ACK (IDLE cycle). Minimum transaction period is WAIT_CYCLES+2 cycles.
- Write visibility: a read accepted after a write's ACK returns the new value.
- reset deasserted at edge R: the first request can be accepted at edge R+1.

## Test plan
- Reset: assert reset for 2 cycles → rdy_ = 1, rd_data = 0. Reads of index 0..7 afterwards return 0x00000000.
- Write/read with WAIT_CYCLES = 2:
  - Write 0xDEADBEEF to 0x14 (index 5) at edge T → rdy_ low only in cycle T+3, rd_data = 0.
  - Read 0x14 → 0xDEADBEEF with rdy_ low 3 cycles after accept.
  - Read 0x34 → 0xDEADBEEF (alias).
- Ignored strobes:
  - as_ = 0 with cs_ = 1 → no rdy_ pulse ever.
  - Extra as_ pulses during WAIT → exactly one rdy_ pulse, and CNT increases by 1.
- CNT:
  - Perform 3 transactions, then read index 7 → 0x00000003.
  - Write 0x12345678 to index 7, then read index 7 → 0x00000005.
- Reset mid-transaction: write 0xA5A5A5A5 to index 1, assert reset during WAIT → no rdy_ pulse; a later read of index 1 returns 0 and CNT = 0.
- WAIT_CYCLES = 0 build: back-to-back reads of indices 0 and 1 accepted 2 cycles apart, each with rdy_ low exactly 1 cycle after accept.
